// File: rtl/neo_vram_pkg.sv
// Shared state encoding, CPU register indices and address-step helper
// for the VRAM CPU write port.
package neo_vram_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACK  = 2'd2,
    INC  = 2'd3
  } vram_state_t;

  localparam logic [1:0] REG_ADDR   = 2'd0;
  localparam logic [1:0] REG_DATA   = 2'd1;
  localparam logic [1:0] REG_MOD    = 2'd2;
  localparam logic [7:0] WDOG_LIMIT = 8'd255;

  // Bit 15 picks the VRAM bank and is never touched by the auto-increment.
  function automatic logic [15:0] step_addr(input logic [15:0] addr, input logic [14:0] modv);
    step_addr = {addr[15], addr[14:0] + modv};
  endfunction

endpackage

// File: rtl/vram_ack_edge.sv
// Registers the selected active-low VRAM write acknowledge and produces
// single-cycle fall (write started) and rise (write finished) pulses.
module vram_ack_edge (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_ack_n,
  output logic o_fall,
  output logic o_rise
);

  logic r_ack_n;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_ack_n <= 1'b1;
    else          r_ack_n <= i_ack_n;
  end

  assign o_fall = r_ack_n & ~i_ack_n;
  assign o_rise = ~r_ack_n & i_ack_n;

endmodule

// File: rtl/vram_cpu_port.sv
// CPU-side VRAM write port: address/data/modulo registers, a one-deep data
// buffer, request/acknowledge handshake FSM and a stuck-ack watchdog.
module vram_cpu_port
  import neo_vram_pkg::*;
(
  input  logic        CLK_24M,
  input  logic        nRESET,
  input  logic        CPU_WR,
  input  logic [1:0]  CPU_REG,
  input  logic [15:0] CPU_DIN,
  output logic [15:0] CPU_DOUT,
  input  logic        nCPU_WR_HIGH,
  input  logic        nCPU_WR_LOW,
  input  logic [15:0] VRAM_HIGH_READ,
  input  logic [15:0] VRAM_LOW_READ,
  output logic [15:0] VRAM_ADDR,
  output logic        REG_VRAMADDR_MSB,
  output logic [15:0] VRAM_WRITE,
  output logic        nVRAM_WRITE_REQ,
  output logic        BUSY,
  output logic        TIMEOUT_ERR
);

  vram_state_t r_state, w_state_next;
  logic [15:0] r_addr, r_mod, r_wdata, r_buf, r_pend, w_addr_next;
  logic        r_buf_vld, r_pend_vld, r_sel_high, r_nreq, r_err;
  logic [7:0]  r_wdog;
  logic        w_wr_addr, w_wr_data, w_wr_mod, w_ack_n, w_ack_fall, w_ack_rise;
  logic        w_in_wait, w_timeout, w_busy, w_start_req, w_release_req;

  assign w_wr_addr = CPU_WR && (CPU_REG == REG_ADDR);
  assign w_wr_data = CPU_WR && (CPU_REG == REG_DATA);
  assign w_wr_mod  = CPU_WR && (CPU_REG == REG_MOD);

  // Bank selection is frozen when the request starts so a mid-write address
  // change cannot redirect which acknowledge we listen to.
  assign w_ack_n = r_sel_high ? nCPU_WR_HIGH : nCPU_WR_LOW;

  vram_ack_edge u_ack_edge (
    .i_clk   (CLK_24M),
    .i_rst_n (nRESET),
    .i_ack_n (w_ack_n),
    .o_fall  (w_ack_fall),
    .o_rise  (w_ack_rise)
  );

  assign w_in_wait = (r_state == REQ) || (r_state == ACK);
  assign w_timeout = w_in_wait && (r_wdog == WDOG_LIMIT);

  always_ff @(posedge CLK_24M or negedge nRESET) begin
    if (!nRESET) r_state <= IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE: if (w_wr_data) w_state_next = REQ;
      REQ: begin
        if (w_timeout)       w_state_next = IDLE;
        else if (w_ack_fall) w_state_next = ACK;
      end
      ACK: begin
        if (w_timeout)       w_state_next = IDLE;
        else if (w_ack_rise) w_state_next = INC;
      end
      INC: w_state_next = (r_buf_vld || w_wr_data) ? REQ : IDLE;
    endcase
  end

  always_comb begin
    w_busy        = (r_state != IDLE);
    w_start_req   = (w_state_next == REQ) && (r_state != REQ);
    w_release_req = (r_state == REQ) && (w_state_next != REQ);
  end

  // A pending address (or one written during INC itself) overrides the step.
  always_comb begin
    w_addr_next = r_addr;
    if (r_state == INC) begin
      if (w_wr_addr)       w_addr_next = CPU_DIN;
      else if (r_pend_vld) w_addr_next = r_pend;
      else                 w_addr_next = step_addr(r_addr, r_mod[14:0]);
    end else if (w_wr_addr && (r_state == IDLE)) begin
      w_addr_next = CPU_DIN;
    end
  end

  always_ff @(posedge CLK_24M or negedge nRESET) begin
    if (!nRESET) begin
      r_addr     <= '0;
      r_mod      <= '0;
      r_wdata    <= '0;
      r_buf      <= '0;
      r_buf_vld  <= 1'b0;
      r_pend     <= '0;
      r_pend_vld <= 1'b0;
      r_sel_high <= 1'b0;
      r_nreq     <= 1'b1;
      r_err      <= 1'b0;
      r_wdog     <= '0;
    end else begin
      r_addr <= w_addr_next;

      if (w_wr_mod)  r_mod <= CPU_DIN;
      if (w_timeout) r_err <= 1'b1;
      else if (w_wr_mod) r_err <= 1'b0;

      if ((r_state == INC) || w_timeout) begin
        r_pend_vld <= 1'b0;
      end else if (w_wr_addr && w_busy) begin
        r_pend     <= CPU_DIN;
        r_pend_vld <= 1'b1;
      end

      // INC hands the buffer straight to the next request, so it drains here.
      if ((r_state == INC) || w_timeout) begin
        r_buf_vld <= 1'b0;
      end else if (w_wr_data && w_busy) begin
        r_buf     <= CPU_DIN;
        r_buf_vld <= 1'b1;
      end

      if (w_start_req) begin
        r_wdata    <= ((r_state == INC) && !w_wr_data) ? r_buf : CPU_DIN;
        r_sel_high <= w_addr_next[15];
        r_nreq     <= 1'b0;
      end else if (w_release_req) begin
        r_nreq <= 1'b1;
      end

      if (w_in_wait && !w_timeout) r_wdog <= r_wdog + 8'd1;
      else                         r_wdog <= '0;
    end
  end

  always_comb begin
    unique case (CPU_REG)
      REG_ADDR: CPU_DOUT = r_addr;
      REG_DATA: CPU_DOUT = r_addr[15] ? VRAM_HIGH_READ : VRAM_LOW_READ;
      REG_MOD:  CPU_DOUT = r_mod;
      default:  CPU_DOUT = 16'hFFFF;
    endcase
  end

  assign VRAM_ADDR        = r_addr;
  assign REG_VRAMADDR_MSB = r_addr[15];
  assign VRAM_WRITE       = r_wdata;
  assign nVRAM_WRITE_REQ  = r_nreq;
  assign BUSY             = w_busy;
  assign TIMEOUT_ERR      = r_err;

endmodule
